// File: rtl/train_center_cal_pkg.sv
// Shared message codes and FSM state encodings for the center-cal RX and TX blocks.
package train_center_cal_pkg;

    localparam logic [3:0] MSG_NONE       = 4'b0000;
    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_WAIT_START_REQ = 3'd1,
        ST_START_RESP     = 3'd2,
        ST_CAL_ALGO       = 3'd3,
        ST_END_RESP       = 3'd4,
        ST_TEST_FINISHED  = 3'd5
    } cal_state_t;

endpackage

// File: rtl/train_center_cal_rx.sv
// Center-calibration RX responder: answers the partner's start/end requests around
// a local RX point test and reports the latched per-lane result.
module train_center_cal_rx
    import train_center_cal_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [3:0]       i_decoded_sideband_message,
    input  logic             i_sideband_valid,
    input  logic             i_busy_negedge_detected,
    input  logic             i_valid_rx,
    input  logic             i_pt_done,
    input  logic [LANES-1:0] i_rx_lanes_result,
    output logic [3:0]       o_sideband_message,
    output logic             o_valid_tx,
    output logic             o_pt_en,
    output logic             o_mainband_or_valtrain_test,
    output logic [LANES-1:0] o_rx_lanes_result,
    output logic             o_test_ack
);

    cal_state_t state, next_state;
    logic       end_seen, pt_seen;

    logic start_req, end_req, tx_release;
    logic enter_start_resp, enter_cal_algo, enter_end_resp, enter_finished, clear_all;

    assign start_req  = i_sideband_valid && (i_decoded_sideband_message == MSG_START_REQ);
    assign end_req    = i_sideband_valid && (i_decoded_sideband_message == MSG_END_REQ);
    // The sideband mux releases us only when no competing RX-path send holds it.
    assign tx_release = i_busy_negedge_detected && !i_valid_rx;

    assign o_mainband_or_valtrain_test = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE:           if (i_en) next_state = ST_WAIT_START_REQ;
            ST_WAIT_START_REQ: if (start_req) next_state = ST_START_RESP;
            ST_START_RESP:     if (o_valid_tx && tx_release) next_state = ST_CAL_ALGO;
            ST_CAL_ALGO:       if ((end_seen || end_req) && (pt_seen || i_pt_done))
                                   next_state = ST_END_RESP;
            ST_END_RESP:       if (o_valid_tx && tx_release) next_state = ST_TEST_FINISHED;
            ST_TEST_FINISHED:  next_state = ST_TEST_FINISHED;
            default:           next_state = ST_IDLE;
        endcase
        if (state != ST_IDLE && !i_en) next_state = ST_IDLE;
    end

    assign enter_start_resp = (state == ST_START_RESP) ? 1'b0 : (next_state == ST_START_RESP);
    assign enter_cal_algo   = (state == ST_CAL_ALGO)   ? 1'b0 : (next_state == ST_CAL_ALGO);
    assign enter_end_resp   = (state == ST_END_RESP)   ? 1'b0 : (next_state == ST_END_RESP);
    assign enter_finished   = (state == ST_TEST_FINISHED) ? 1'b0 : (next_state == ST_TEST_FINISHED);
    assign clear_all        = (next_state == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sideband_message <= MSG_NONE;
            o_valid_tx         <= 1'b0;
            o_pt_en            <= 1'b0;
            o_rx_lanes_result  <= '0;
            o_test_ack         <= 1'b0;
            end_seen           <= 1'b0;
            pt_seen            <= 1'b0;
        end else if (clear_all) begin
            o_sideband_message <= MSG_NONE;
            o_valid_tx         <= 1'b0;
            o_pt_en            <= 1'b0;
            o_rx_lanes_result  <= '0;
            o_test_ack         <= 1'b0;
            end_seen           <= 1'b0;
            pt_seen            <= 1'b0;
        end else begin
            if (enter_start_resp) o_sideband_message <= MSG_START_RESP;
            if (enter_end_resp)   o_sideband_message <= MSG_END_RESP;
            if (enter_finished)   o_sideband_message <= MSG_NONE;

            // A new send request wins over a release seen in the same cycle.
            if (enter_start_resp || enter_end_resp) o_valid_tx <= 1'b1;
            else if (tx_release)                    o_valid_tx <= 1'b0;

            if (enter_cal_algo)      o_pt_en <= 1'b1;
            else if (enter_end_resp) o_pt_en <= 1'b0;

            if (state == ST_CAL_ALGO && end_req) end_seen <= 1'b1;
            if (state == ST_CAL_ALGO && i_pt_done) begin
                pt_seen           <= 1'b1;
                o_rx_lanes_result <= i_rx_lanes_result;
            end

            if (enter_finished) o_test_ack <= 1'b1;
        end
    end

endmodule

// File: tb/tb_train_center_cal_rx.sv
// Bench for train_center_cal_rx: table-driven nominal flow plus hand-written corner sequences.
module tb_train_center_cal_rx;

    localparam int LANES = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_en;
    logic [3:0]       i_decoded_sideband_message;
    logic             i_sideband_valid;
    logic             i_busy_negedge_detected;
    logic             i_valid_rx;
    logic             i_pt_done;
    logic [LANES-1:0] i_rx_lanes_result;
    logic [3:0]       o_sideband_message;
    logic             o_valid_tx;
    logic             o_pt_en;
    logic             o_mainband_or_valtrain_test;
    logic [LANES-1:0] o_rx_lanes_result;
    logic             o_test_ack;

    train_center_cal_rx #(.LANES(LANES)) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .i_en                        (i_en),
        .i_decoded_sideband_message  (i_decoded_sideband_message),
        .i_sideband_valid            (i_sideband_valid),
        .i_busy_negedge_detected     (i_busy_negedge_detected),
        .i_valid_rx                  (i_valid_rx),
        .i_pt_done                   (i_pt_done),
        .i_rx_lanes_result           (i_rx_lanes_result),
        .o_sideband_message          (o_sideband_message),
        .o_valid_tx                  (o_valid_tx),
        .o_pt_en                     (o_pt_en),
        .o_mainband_or_valtrain_test (o_mainband_or_valtrain_test),
        .o_rx_lanes_result           (o_rx_lanes_result),
        .o_test_ack                  (o_test_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       msg;
        logic             vtx;
        logic             pten;
        logic             ack;
        logic             mb;
        logic [LANES-1:0] lanes;
    } out_t;

    typedef struct {
        string            name;
        logic             en;
        logic             sbv;
        logic [3:0]       msg;
        logic             busy;
        logic             vrx;
        logic             ptd;
        logic [LANES-1:0] lanes;
        out_t             exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    out_t  exp_q[$];
    string name_q[$];

    function automatic out_t outs(logic [3:0] m, logic vtx, logic pten, logic ack, logic [LANES-1:0] ln);
        out_t o;
        o.msg = m; o.vtx = vtx; o.pten = pten; o.ack = ack; o.mb = 1'b0; o.lanes = ln;
        return o;
    endfunction

    function automatic vec_t mk(string nm, logic en, logic sbv, logic [3:0] m, logic busy, logic vrx,
                                logic ptd, logic [LANES-1:0] ln, out_t e);
        vec_t v;
        v.name = nm; v.en = en; v.sbv = sbv; v.msg = m; v.busy = busy; v.vrx = vrx;
        v.ptd = ptd; v.lanes = ln; v.exp = e;
        return v;
    endfunction

    function automatic out_t dut_outs();
        out_t o;
        o.msg = o_sideband_message; o.vtx = o_valid_tx; o.pten = o_pt_en;
        o.ack = o_test_ack; o.mb = o_mainband_or_valtrain_test; o.lanes = o_rx_lanes_result;
        return o;
    endfunction

    task automatic check(input string nm, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got msg=%h vtx=%b pten=%b ack=%b mb=%b lanes=%h, want msg=%h vtx=%b pten=%b ack=%b mb=%b lanes=%h",
                     nm, act.msg, act.vtx, act.pten, act.ack, act.mb, act.lanes,
                     exp.msg, exp.vtx, exp.pten, exp.ack, exp.mb, exp.lanes);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare one step after the edge.
    task automatic apply(input vec_t v);
        i_en                       = v.en;
        i_sideband_valid           = v.sbv;
        i_decoded_sideband_message = v.msg;
        i_busy_negedge_detected    = v.busy;
        i_valid_rx                 = v.vrx;
        i_pt_done                  = v.ptd;
        i_rx_lanes_result          = v.lanes;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(posedge clk);
        #1;
        check(name_q.pop_front(), dut_outs(), exp_q.pop_front());
    endtask

    task automatic to_cal_algo(input string tag);
        apply(mk({tag, "_en"},    1, 0, 4'h0, 0, 0, 0, 16'h0, outs(4'h0, 0, 0, 0, 16'h0)));
        apply(mk({tag, "_start"}, 1, 1, 4'h1, 0, 0, 0, 16'h0, outs(4'h2, 1, 0, 0, 16'h0)));
        apply(mk({tag, "_busy"},  1, 0, 4'h0, 1, 0, 0, 16'h0, outs(4'h2, 0, 1, 0, 16'h0)));
    endtask

    vec_t nominal[$];

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nominal = '{
            mk("wait_entry",   1, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)),
            mk("stray_end",    1, 1, 4'h3, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)),
            mk("start_req",    1, 1, 4'h1, 0, 0, 0, 16'h0000, outs(4'h2, 1, 0, 0, 16'h0000)),
            mk("held_by_vrx",  1, 0, 4'h0, 1, 1, 0, 16'h0000, outs(4'h2, 1, 0, 0, 16'h0000)),
            mk("resp_hold",    1, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h2, 1, 0, 0, 16'h0000)),
            mk("start_rel",    1, 0, 4'h0, 1, 0, 0, 16'h0000, outs(4'h2, 0, 1, 0, 16'h0000)),
            mk("repeat_start", 1, 1, 4'h1, 0, 0, 0, 16'h0000, outs(4'h2, 0, 1, 0, 16'h0000)),
            mk("pt_done",      1, 0, 4'h0, 0, 0, 1, 16'hFFF0, outs(4'h2, 0, 1, 0, 16'hFFF0)),
            mk("lanes_held",   1, 0, 4'h0, 0, 0, 0, 16'h1234, outs(4'h2, 0, 1, 0, 16'hFFF0)),
            mk("end_req",      1, 1, 4'h3, 0, 0, 0, 16'h0000, outs(4'h4, 1, 0, 0, 16'hFFF0)),
            mk("end_rel",      1, 0, 4'h0, 1, 0, 0, 16'h0000, outs(4'h0, 0, 0, 1, 16'hFFF0)),
            mk("finished",     1, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 1, 16'hFFF0)),
            mk("en_drop",      0, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000))
        };

        rst_n = 1'b0; i_en = 1'b0; i_sideband_valid = 1'b0; i_decoded_sideband_message = 4'h0;
        i_busy_negedge_detected = 1'b0; i_valid_rx = 1'b0; i_pt_done = 1'b0; i_rx_lanes_result = '0;
        #12;
        check("reset", dut_outs(), outs(4'h0, 0, 0, 0, 16'h0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (nominal[i]) apply(nominal[i]);

        // END_REQ and pt_done in the same cycle move straight to END_RESP.
        to_cal_algo("same");
        apply(mk("same_both", 1, 1, 4'h3, 0, 0, 1, 16'h00AA, outs(4'h4, 1, 0, 0, 16'h00AA)));
        apply(mk("same_rel",  1, 0, 4'h0, 1, 0, 0, 16'h0000, outs(4'h0, 0, 0, 1, 16'h00AA)));
        apply(mk("same_drop", 0, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)));

        // Early END_REQ: point test stays enabled until pt_done arrives 20 cycles later.
        to_cal_algo("early");
        apply(mk("early_end", 1, 1, 4'h3, 0, 0, 0, 16'h0000, outs(4'h2, 0, 1, 0, 16'h0000)));
        for (int c = 0; c < 20; c++)
            apply(mk($sformatf("early_wait%0d", c), 1, 0, 4'h0, 0, 0, 0, 16'h0000,
                     outs(4'h2, 0, 1, 0, 16'h0000)));
        apply(mk("early_pt",  1, 0, 4'h0, 0, 0, 1, 16'h5555, outs(4'h4, 1, 0, 0, 16'h5555)));
        apply(mk("early_vrx", 1, 0, 4'h0, 1, 1, 0, 16'h0000, outs(4'h4, 1, 0, 0, 16'h5555)));
        apply(mk("early_rel", 1, 0, 4'h0, 1, 0, 0, 16'h0000, outs(4'h0, 0, 0, 1, 16'h5555)));

        // Dropping i_en mid-calibration clears everything; re-enable restarts at WAIT_START_REQ.
        apply(mk("abort_drop", 0, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)));
        to_cal_algo("abort");
        apply(mk("abort_pt",    1, 0, 4'h0, 0, 0, 1, 16'hBEEF, outs(4'h2, 0, 1, 0, 16'hBEEF)));
        apply(mk("abort_en0",   0, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)));
        apply(mk("abort_en1",   1, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)));
        apply(mk("abort_start", 1, 1, 4'h1, 0, 0, 0, 16'h0000, outs(4'h2, 1, 0, 0, 16'h0000)));
        apply(mk("abort_end",   0, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)));

        // Asynchronous reset in the middle of END_RESP, away from any clock edge.
        to_cal_algo("rst");
        apply(mk("rst_end", 1, 1, 4'h3, 0, 0, 1, 16'h0F0F, outs(4'h4, 1, 0, 0, 16'h0F0F)));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_outs(), outs(4'h0, 0, 0, 0, 16'h0000));
        i_en = 1'b0; i_sideband_valid = 1'b0; i_pt_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(mk("post_rst_en",    1, 0, 4'h0, 0, 0, 0, 16'h0000, outs(4'h0, 0, 0, 0, 16'h0000)));
        apply(mk("post_rst_start", 1, 1, 4'h1, 0, 0, 0, 16'h0000, outs(4'h2, 1, 0, 0, 16'h0000)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
